spi_atten_scheduler: RTL and testbench

- Sequences the attenuator SPI serializer on the ZCU111 daughter-board path.
- Arbitrates round-robin among NUM_CH attenuator-channel requesters and builds the frame word for the winner.
- Drives the serializer's parallel data input and one-cycle load strobe, then tracks serializer chip-select to detect the end of the transfer.
- Enforces an inter-frame gap and flags a sticky error on a start timeout.

---
 rtl/spi_atten_scheduler.sv | 167 ++++++++++++++++
 tb/tb_spi_atten_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_atten_scheduler.sv
// Round-robin scheduler that feeds attenuator frames to the SPI serializer and tracks its chip-select.
// Optional build macro SPI_ATTEN_SHADOW_EN suppresses frames whose value matches the last one sent.
module spi_atten_scheduler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned REG_W      = 32,
  parameter logic [7:0]  ADDR_BASE  = 8'h10,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned START_TO   = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*8-1:0]   atten_val,
  output logic [NUM_CH-1:0]     gnt,
  output logic [REG_W-1:0]      spi_word,
  output logic                  spi_ld,
  input  logic                  spi_cs,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StWaitStart, StWaitDone, StGap} state_e;

  state_e           state_q;
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  win_idx;
  logic [PtrW-1:0]  ptr_nxt;
  logic             win_found;
  logic [7:0]       win_val;
  logic [REG_W-1:0] win_word;
  logic [31:0]      cnt_q;
  logic             cs_s1_q, cs_s2_q, cs_s3_q;
  logic             cs_rise;
  logic             skip;

  function automatic logic [PtrW-1:0] wrap_idx(input int unsigned p, input int unsigned k);
    int unsigned j = p + k;
    if (j >= NUM_CH) j = j - NUM_CH;
    return PtrW'(j);
  endfunction

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!win_found && req[wrap_idx(int'(ptr_q), k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(int'(ptr_q), k);
      end
    end
  end

  always_comb begin
    win_val         = atten_val[{win_idx, 3'b000} +: 8];
    win_word        = '0;
    win_word[23:16] = ADDR_BASE + 8'(win_idx);
    win_word[7:0]   = win_val;
    ptr_nxt         = (win_idx == PtrW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
  end

  assign cs_rise = cs_s2_q & ~cs_s3_q;

`ifdef SPI_ATTEN_SHADOW_EN
  logic [7:0]        shadow_q [NUM_CH];
  logic [NUM_CH-1:0] shadow_vld_q;
  logic [PtrW-1:0]   cur_idx_q;

  assign skip = shadow_vld_q[win_idx] && (shadow_q[win_idx] == win_val);

  // Shadow only learns values that completed a frame, never a timed-out one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      shadow_vld_q <= '0;
      cur_idx_q    <= '0;
    end else begin
      if (state_q == StIdle && win_found) cur_idx_q <= win_idx;
      if (state_q == StWaitDone && cs_rise) begin
        shadow_q[cur_idx_q]     <= spi_word[7:0];
        shadow_vld_q[cur_idx_q] <= 1'b1;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cnt_q    <= '0;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_s3_q  <= 1'b1;
      gnt      <= '0;
      spi_word <= '0;
      spi_ld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cs_s1_q <= spi_cs;
      cs_s2_q <= cs_s1_q;
      cs_s3_q <= cs_s2_q;
      gnt     <= '0;
      spi_ld  <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StLoad;
            busy    <= 1'b1;
            gnt     <= NUM_CH'(1) << win_idx;
            ptr_q   <= ptr_nxt;
            if (!skip) begin
              spi_word <= win_word;
              spi_ld   <= 1'b1;
            end
          end
        end
        StLoad: begin
          // The strobe cycle counts toward the start timeout.
          cnt_q <= 32'd1;
          if (spi_ld) begin
            state_q <= StWaitStart;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StWaitStart: begin
          if (!cs_s2_q) begin
            state_q <= StWaitDone;
          end else if (cnt_q >= 32'(START_TO - 1)) begin
            err     <= 1'b1;
            state_q <= StGap;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StWaitDone: begin
          if (cs_rise) begin
            done    <= 1'b1;
            state_q <= StGap;
            cnt_q   <= '0;
          end
        end
        StGap: begin
          if (cnt_q >= 32'(GAP_CYCLES - 1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_atten_scheduler.sv
// Directed plus randomized bench for spi_atten_scheduler with a transaction-level reference model.
module tb_spi_atten_scheduler;
  localparam int NUM_CH = 4;
  localparam logic [7:0] ADDR_BASE = 8'h10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] atten_val = '0;
  logic        spi_cs = 1'b1;
  logic [3:0]  gnt;
  logic [31:0] spi_word;
  logic        spi_ld, busy, done, err;

  spi_atten_scheduler dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .atten_val (atten_val),
    .gnt       (gnt),
    .spi_word  (spi_word),
    .spi_ld    (spi_ld),
    .spi_cs    (spi_cs),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         ptr_m = 0;
  logic [7:0] shadow_m [NUM_CH];
  bit         valid_m [NUM_CH];
  bit         err_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NUM_CH; k++) if (r[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    return -1;
  endfunction

  task automatic clear_model();
    ptr_m = 0;
    err_m = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_m[c] = '0;
      valid_m[c]  = 0;
    end
  endtask

  // Called on an idle negedge right after req/atten_val were driven.
  task automatic serve(input int idx, input int low_len, input logic [3:0] req_after);
    logic [7:0] val;
    bit skip, early, ld_gap;
    val  = atten_val[8*idx +: 8];
    skip = 0;
`ifdef SPI_ATTEN_SHADOW_EN
    skip = valid_m[idx] && (shadow_m[idx] == val);
`endif
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(1) << idx);
    chk("spi_ld", 32'(spi_ld), 32'(!skip));
    chk("err_level", 32'(err), 32'(err_m));
    req   = req_after;
    ptr_m = (idx + 1) % NUM_CH;
    if (skip) begin
      @(negedge clk);
      chk("skip_back_idle", 32'({busy, done, spi_ld, gnt != 4'd0}), 32'd0);
      return;
    end
    chk("spi_word", spi_word, {8'h00, 8'(ADDR_BASE + 8'(idx)), 8'h00, val});
    spi_cs = 1'b0;
    repeat (low_len) @(negedge clk);
    spi_cs = 1'b1;
    early = 0;
    repeat (2) begin
      @(negedge clk);
      early |= done;
    end
    @(negedge clk);
    chk("done_early", 32'(early), 32'd0);
    chk("done_latency", 32'(done), 32'd1);
    shadow_m[idx] = val;
    valid_m[idx]  = 1;
    ld_gap = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_gap |= spi_ld;
      if (i == 0) chk("done_one_cycle", 32'(done), 32'd0);
      if (i == 14) chk("busy_in_gap", 32'(busy), 32'd1);
    end
    chk("busy_after_gap", 32'(busy), 32'd0);
    chk("ld_in_gap", 32'(ld_gap), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_err, seen_done, seen_ld;
    clear_model();
    repeat (3) @(negedge clk);
    chk("reset_word", spi_word, 32'd0);
    chk("reset_ctrl", 32'({gnt, spi_ld, busy, done, err}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Round-robin with all requests held
    atten_val = 32'h04030201;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) serve(rr_pick(req, ptr_m), 6 + n, 4'b1111);
    req = '0;
    @(negedge clk);

    // Single request on ch2
    atten_val = 32'h003C0000;
    req = 4'b0100;
    serve(rr_pick(req, ptr_m), 24, 4'b0000);

    // Start timeout with CS held high
    atten_val = 32'h000000AA;
    req = 4'b0001;
    @(negedge clk);
    chk("to_gnt", 32'(gnt), 32'd1);
    chk("to_ld", 32'(spi_ld), 32'd1);
    req = '0;
    ptr_m = 1;
    seen_err = 0;
    seen_done = 0;
    repeat (1023) begin
      @(negedge clk);
      seen_err |= err;
      seen_done |= done;
    end
    chk("err_before_timeout", 32'(seen_err), 32'd0);
    @(negedge clk);
    chk("err_at_timeout", 32'(err), 32'd1);
    err_m = 1;
    repeat (20) begin
      @(negedge clk);
      seen_done |= done;
    end
    chk("to_no_done", 32'(seen_done), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    atten_val = 32'h00005500;
    req = 4'b0010;
    serve(rr_pick(req, ptr_m), 5, 4'b0000);

    // Reset while the serializer frame is in flight
    atten_val = 32'h00006600;
    req = 4'b0010;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'b0010);
    req = '0;
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_reset_word", spi_word, 32'd0);
    chk("mid_reset_ctrl", 32'({gnt, spi_ld, busy, done, err}), 32'd0);
    spi_cs = 1'b1;
    clear_model();
    @(negedge clk);
    resetn = 1'b1;
    atten_val = 32'h00770077;
    req = 4'b0101;
    serve(rr_pick(req, ptr_m), 4, 4'b0000);

    // Drop-out: ch1 withdraws while ch0 is being served
    atten_val = 32'h88000000;
    req = 4'b1000;
    serve(rr_pick(req, ptr_m), 3, 4'b0000);
    atten_val = 32'h00001199;
    req = 4'b0011;
    serve(rr_pick(req, ptr_m), 8, 4'b0000);
    seen_ld = 0;
    repeat (20) begin
      @(negedge clk);
      seen_ld |= spi_ld;
    end
    chk("dropout_no_ld", 32'(seen_ld), 32'd0);
    chk("dropout_idle", 32'(busy), 32'd0);

    // Repeated value on one channel, then a changed value
    atten_val = 32'h00002000;
    req = 4'b0010;
    serve(rr_pick(req, ptr_m), 5, 4'b0000);
    req = 4'b0010;
    serve(rr_pick(req, ptr_m), 5, 4'b0000);
    atten_val = 32'h00002100;
    req = 4'b0010;
    serve(rr_pick(req, ptr_m), 5, 4'b0000);

    // Randomized requests and values
    for (int it = 0; it < 24; it++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++)
        atten_val[8*c +: 8] = ($urandom_range(0, 2) == 0) ? 8'h20 : 8'($urandom);
      req = r;
      serve(rr_pick(r, ptr_m), $urandom_range(1, 30), 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
